// File: rtl/factorial_iter_param.sv
// Iterative n! unit: multiply-and-decrement loop, pulses fin with the result on salida.
// Latency max(n,1)+1 edges from the accepting edge; inicio is ignored while busy.
module factorial_iter_param #(
  parameter int N_W      = 3,
  parameter int OUT_W    = 13,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inicio,
  input  logic             abortar,
  input  logic [N_W-1:0]   n,
  output logic [OUT_W-1:0] salida,
  output logic             ovf,
  output logic             busy,
  output logic             fin
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CALC = 1'b1;

  logic [0:0]           state;
  logic [OUT_W-1:0]     acc;
  logic [N_W-1:0]       cnt;
  logic                 ovf_acc;
  logic [OUT_W+N_W-1:0] prod;

  // Full-width product so the bits above OUT_W reveal overflow on each step.
  assign prod = {{N_W{1'b0}}, acc} * {{OUT_W{1'b0}}, cnt};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      acc     <= OUT_W'(1);
      cnt     <= '0;
      ovf_acc <= 1'b0;
      salida  <= '0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      fin     <= 1'b0;
    end else begin
      fin <= 1'b0;
      case (state)
        S_IDLE: begin
          if (inicio) begin
            cnt     <= n;
            acc     <= OUT_W'(1);
            ovf_acc <= 1'b0;
            state   <= S_CALC;
            busy    <= 1'b1;
          end
        end
        default: begin
          if (abortar) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (cnt <= N_W'(1)) begin
            salida <= (SATURATE != 0 && ovf_acc) ? '1 : acc;
            ovf    <= ovf_acc;
            fin    <= 1'b1;
            state  <= S_IDLE;
            busy   <= 1'b0;
          end else begin
            acc     <= prod[OUT_W-1:0];
            ovf_acc <= ovf_acc | (prod[OUT_W+N_W-1:OUT_W] != '0);
            cnt     <= cnt - N_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_factorial_iter_param.sv
// Bench: default, 8-bit wrapping and 8-bit saturating instances share one stimulus stream.
module tb_factorial_iter_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        inicio;
  logic        abortar;
  logic [2:0]  n;
  logic [12:0] s0;
  logic [7:0]  s1, s2;
  logic        o0, o1, o2, b0, b1, b2, f0, f1, f2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  factorial_iter_param #(.N_W(3), .OUT_W(13), .SATURATE(0)) d0 (
    .clk(clk), .rst(rst), .inicio(inicio), .abortar(abortar), .n(n),
    .salida(s0), .ovf(o0), .busy(b0), .fin(f0));
  factorial_iter_param #(.N_W(3), .OUT_W(8), .SATURATE(0)) d1 (
    .clk(clk), .rst(rst), .inicio(inicio), .abortar(abortar), .n(n),
    .salida(s1), .ovf(o1), .busy(b1), .fin(f1));
  factorial_iter_param #(.N_W(3), .OUT_W(8), .SATURATE(1)) d2 (
    .clk(clk), .rst(rst), .inicio(inicio), .abortar(abortar), .n(n),
    .salida(s2), .ovf(o2), .busy(b2), .fin(f2));

  typedef struct {
    int n;
    int sal13;
    int ovf13;
    int sal8w;
    int sal8s;
    int ovf8;
    int lat;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: true factorial, then reduce to the output width.
  function automatic longint fact(input int k);
    longint f = 1;
    for (int i = 2; i <= k; i++) f = f * i;
    return f;
  endfunction

  function automatic int ref_sal(input int k, input int w, input int sat);
    longint f = fact(k);
    longint lim = longint'(1) << w;
    if (f >= lim) return (sat != 0) ? int'(lim - 1) : int'(f % lim);
    return int'(f);
  endfunction

  function automatic int ref_ovf(input int k, input int w);
    return (fact(k) >= (longint'(1) << w)) ? 1 : 0;
  endfunction

  task automatic job(input string tag, input int nv, input bit hold,
                     input int e13, input int eo13, input int e8w,
                     input int e8s, input int eo8, input int elat);
    int lat = 0;
    int bcnt = 0;
    bit got = 1'b0;
    @(posedge clk); #1;
    n = 3'(nv);
    inicio = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (!hold) inicio = 1'b0;
      lat++;
      if (b0) bcnt++;
      if (f0) begin
        got = 1'b1;
        break;
      end
    end
    inicio = 1'b0;
    chk({tag, "_fin_seen"}, int'(got), 1);
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_busy_cycles"}, bcnt, elat - 1);
    chk({tag, "_fin_all"}, int'({f1, f2}), 3);
    chk({tag, "_sal13"}, int'(s0), e13);
    chk({tag, "_ovf13"}, int'(o0), eo13);
    chk({tag, "_sal8w"}, int'(s1), e8w);
    chk({tag, "_sal8s"}, int'(s2), e8s);
    chk({tag, "_ovf8"}, int'({o1, o2}), eo8 ? 3 : 0);
    // fin is a single-cycle pulse and nothing restarts afterwards
    bcnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (f0 || b0) bcnt++;
    end
    chk({tag, "_quiet_after"}, bcnt, 0);
  endtask

  initial begin
    int fins;
    tbl[0] = '{0, 1, 0, 1, 1, 0, 2};
    tbl[1] = '{1, 1, 0, 1, 1, 0, 2};
    tbl[2] = '{2, 2, 0, 2, 2, 0, 3};
    tbl[3] = '{3, 6, 0, 6, 6, 0, 4};
    tbl[4] = '{4, 24, 0, 24, 24, 0, 5};
    tbl[5] = '{5, 120, 0, 120, 120, 0, 6};
    tbl[6] = '{6, 720, 0, 208, 255, 1, 7};
    tbl[7] = '{7, 5040, 0, 176, 255, 1, 8};

    rst = 1'b1; inicio = 1'b0; abortar = 1'b0; n = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_salida", int'(s0), 0);
    chk("reset_ovf", int'(o0), 0);
    chk("reset_busy", int'(b0), 0);
    chk("reset_fin", int'(f0), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      job($sformatf("tbl_n%0d", tbl[i].n), tbl[i].n, 1'b0, tbl[i].sal13,
          tbl[i].ovf13, tbl[i].sal8w, tbl[i].sal8s, tbl[i].ovf8, tbl[i].lat);

    // inicio held high throughout the computation
    job("hold_n7", 7, 1'b1, 5040, 0, 176, 255, 1, 8);

    // abort three cycles into n=6
    @(posedge clk); #1;
    n = 3'd6; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    abortar = 1'b1;
    @(posedge clk); #1;
    abortar = 1'b0;
    chk("abort_busy", int'(b0), 0);
    chk("abort_fin", int'(f0), 0);
    chk("abort_sal_kept", int'(s0), 5040);
    fins = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (f0) fins++;
    end
    chk("abort_no_fin", fins, 0);
    job("after_abort_n4", 4, 1'b0, 24, 0, 24, 24, 0, 5);

    // reset in the middle of a job
    @(posedge clk); #1;
    n = 3'd6; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out", int'({s0, o0, b0, f0}), 0);
    fins = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (f0 || b0) fins++;
    end
    chk("midrst_no_fin", fins, 0);
    job("after_rst_n3", 3, 1'b0, 6, 0, 6, 6, 0, 4);

    // randomized jobs against the arithmetic model
    for (int r = 0; r < 25; r++) begin
      int nv = int'($urandom_range(0, 7));
      int gap = int'($urandom_range(0, 3));
      repeat (gap) @(posedge clk);
      job($sformatf("rnd%0d_n%0d", r, nv), nv, 1'(($urandom & 1)),
          ref_sal(nv, 13, 0), ref_ovf(nv, 13), ref_sal(nv, 8, 0),
          ref_sal(nv, 8, 1), ref_ovf(nv, 8), ((nv > 1) ? nv : 1) + 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
